// File: rtl/nibble_serial_adder_ctrl_if.sv
// nibble_serial_adder_ctrl_if: operand/start handshake and result bus of the nibble-serial adder
interface nibble_serial_adder_ctrl_if;
  logic        start;
  logic        sub;
  logic        c_in;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;
  modport master (output start, sub, c_in, a, b, input busy, done, sum, c_out, ovf);
  modport slave  (input start, sub, c_in, a, b, output busy, done, sum, c_out, ovf);
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: 16-bit add/subtract sequenced over one 4-bit carry-lookahead adder
module four_bit_carry_lookahead_adder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c
);
  logic [3:0] w_g, w_p;
  logic [4:0] w_c;
  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;
  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (&w_p[1:0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (&w_p[2:1] & w_g[0]) | (&w_p[2:0] & i_c);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (&w_p[3:2] & w_g[1]) | (&w_p[3:1] & w_g[0])
                | (&w_p[3:0] & i_c);
  assign o_s = w_p ^ w_c[3:0];
  assign o_c = w_c[4];
endmodule

module nibble_serial_adder_ctrl (
  input  logic                        clk,
  input  logic                        clr,
  nibble_serial_adder_ctrl_if.slave   s
);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_a, r_b, r_acc, r_sum, w_acc;
  logic [1:0]  r_idx;
  logic        r_cy, r_c_out, r_ovf;
  logic [3:0]  w_an, w_bn, w_s;
  logic        w_co, w_accept, w_last;
  assign w_an = r_a[{r_idx, 2'b00} +: 4];
  assign w_bn = r_b[{r_idx, 2'b00} +: 4];
  four_bit_carry_lookahead_adder u_cla (
    .i_a (w_an),
    .i_b (w_bn),
    .i_c (r_cy),
    .o_s (w_s),
    .o_c (w_co)
  );
  always_comb begin
    w_accept = (r_state != ADD) && s.start;
    w_last   = (r_state == ADD) && (r_idx == 2'd3);
    w_next   = (r_state == ADD) ? (w_last ? DONE : ADD) : (s.start ? ADD : IDLE);
    w_acc    = r_acc;
    w_acc[{r_idx, 2'b00} +: 4] = w_s;
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) r_state <= IDLE;
    else     r_state <= w_next;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_cy    <= 1'b0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a   <= s.a;
      r_b   <= s.sub ? ~s.b : s.b;
      r_cy  <= s.sub | s.c_in;
      r_idx <= '0;
    end else if (r_state == ADD) begin
      r_acc <= w_acc;
      r_cy  <= w_co;
      r_idx <= r_idx + 2'd1;
      if (w_last) begin
        r_sum   <= w_acc;
        r_c_out <= w_co;
        // carry into bit 15 is a15^b15^s15; overflow is that XOR the carry out
        r_ovf   <= r_a[15] ^ r_b[15] ^ w_s[3] ^ w_co;
      end
    end
  end
  assign s.busy  = (r_state == ADD);
  assign s.done  = (r_state == DONE);
  assign s.sum   = r_sum;
  assign s.c_out = r_c_out;
  assign s.ovf   = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: random and directed checks against an arithmetic reference model
module tb_nibble_serial_adder_ctrl;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_pass = 0;
  int   n_tot  = 0;
  nibble_serial_adder_ctrl_if bus ();
  nibble_serial_adder_ctrl dut (.clk(clk), .clr(clr), .s(bus.slave));
  always #5 clk = ~clk;

  // packed result: {c_out, ovf, sum}
  function automatic logic [17:0] ref_op(logic [15:0] x, logic [15:0] y, logic sb, logic ci);
    logic [15:0] yy;
    logic        c;
    logic [16:0] u;
    int          sv;
    yy = sb ? ~y : y;
    c  = sb ? 1'b1 : ci;
    u  = {1'b0, x} + {1'b0, yy} + {16'd0, c};
    sv = int'($signed(x)) + int'($signed(yy)) + int'(c);
    return {u[16], (sv > 32767 || sv < -32768), u[15:0]};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  logic        m_busy, m_done;
  int          m_cnt;
  logic [17:0] m_pend, m_res;
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else if (!m_busy && bus.start) begin
      m_pend <= ref_op(bus.a, bus.b, bus.sub, bus.c_in);
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_cnt  <= 4;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= m_pend;
      end
    end else m_done <= 1'b0;
  end

  bit chk_on = 1'b0;
  always @(negedge clk) if (chk_on && !clr) begin
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("result", {14'd0, bus.c_out, bus.ovf, bus.sum}, {14'd0, m_res});
  end

  task automatic op(input string n, input logic [15:0] x, input logic [15:0] y, input logic sb,
                    input logic ci, input logic [17:0] e, input bit poke, input bit lat);
    int k, nb;
    @(posedge clk); #1;
    bus.a = x; bus.b = y; bus.sub = sb; bus.c_in = ci; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
    bus.sub = 1'($urandom); bus.c_in = 1'($urandom);
    if (poke) begin
      @(posedge clk); #1;
      bus.start = 1'b1; bus.a = 16'hA5A5; bus.b = 16'h5A5A;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    k = 0; nb = 0;
    while (!bus.done && k < 12) begin
      @(negedge clk);
      k++;
      if (bus.busy) nb++;
    end
    chk({n, " timeout"}, 32'(k < 12), 32'd1);
    if (lat) begin
      chk({n, " latency"}, k, 5);
      chk({n, " busy cycles"}, nb, 4);
    end
    chk(n, {14'd0, bus.c_out, bus.ovf, bus.sum}, {14'd0, e});
  endtask

  initial begin
    int nd;
    logic [15:0] hs;
    logic [15:0] ra, rb;
    logic        rs, rc;
    bus.start = 1'b0; bus.sub = 1'b0; bus.c_in = 1'b0; bus.a = '0; bus.b = '0;
    chk("pin add", 32'(ref_op(16'h1234, 16'h4321, 1'b0, 1'b0)), 32'h05555);
    chk("pin ripple", 32'(ref_op(16'hFFFF, 16'h0000, 1'b0, 1'b1)), 32'h20000);
    chk("pin ovf", 32'(ref_op(16'h7FFF, 16'h0001, 1'b0, 1'b0)), 32'h18000);
    chk("pin sub", 32'(ref_op(16'h0005, 16'h0007, 1'b1, 1'b0)), 32'h0FFFE);
    chk("pin sub ovf", 32'(ref_op(16'h8000, 16'h0001, 1'b1, 1'b1)), 32'h37FFF);
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {bus.busy, bus.done, bus.c_out, bus.ovf, bus.sum}, '0);
    clr = 1'b0;
    chk_on = 1'b1;
    // reset in the middle of an operation
    @(posedge clk); #1;
    bus.a = 16'hFFFF; bus.b = 16'h0001; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b1;
    #1 chk("mid-op reset", {bus.busy, bus.done, bus.c_out, bus.ovf, bus.sum}, '0);
    @(posedge clk); #1 clr = 1'b0;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("no done after reset", nd, 0);
    op("basic add", 16'h1234, 16'h4321, 1'b0, 1'b0, 18'h05555, 1'b0, 1'b1);
    op("ripple", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 18'h20000, 1'b0, 1'b0);
    op("add ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h18000, 1'b0, 1'b0);
    op("sub neg", 16'h0005, 16'h0007, 1'b1, 1'b0, 18'h0FFFE, 1'b0, 1'b1);
    op("sub neg cin", 16'h0005, 16'h0007, 1'b1, 1'b1, 18'h0FFFE, 1'b0, 1'b0);
    op("sub ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 18'h37FFF, 1'b0, 1'b0);
    op("sub ovf cin", 16'h8000, 16'h0001, 1'b1, 1'b1, 18'h37FFF, 1'b0, 1'b0);
    op("start in ADD", 16'h1234, 16'h4321, 1'b0, 1'b0, 18'h05555, 1'b1, 1'b0);
    // result must hold while operands wander without start
    hs = bus.sum;
    repeat (20) begin
      @(posedge clk); #1;
      bus.a = 16'($urandom); bus.b = 16'($urandom);
      @(negedge clk);
      chk("hold sum", 32'(bus.sum), 32'(hs));
    end
    // back-to-back with start held high
    @(posedge clk); #1;
    bus.start = 1'b1;
    nd = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) nd++;
      @(posedge clk); #1;
      bus.a = 16'($urandom); bus.b = 16'($urandom);
      bus.sub = 1'($urandom); bus.c_in = 1'($urandom);
    end
    bus.start = 1'b0;
    chk("b2b done count", nd, 11);
    repeat (8) @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      if (i < 4) rb = 16'hFFFF - ra + 16'(i & 1);
      op("random op", ra, rb, rs, rc, ref_op(ra, rb, rs, rc), 1'b0, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1 chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that performs 16-bit add/subtract by time-multiplexing one `four_bit_carry_lookahead_adder` instance over four nibble cycles. Operands are captured on a start handshake, nibbles are processed LSB first with the carry registered between cycles, and the 16-bit result, carry-out and signed-overflow flags are published together with a one-cycle `done` pulse. The block sits between switch/operand capture logic and `four_dig_svn_seg_display`, whose four digits are driven directly from the 16-bit `sum`.

## Interface
- No parameters; width is fixed at 16 bits (4 nibbles).
- `clk`  in  1  system clock; all state changes on rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled on rising edge in IDLE or DONE only.
- `sub`  in  1  0 = a+b+c_in, 1 = a−b (captured with operands).
- `a`  in  16  operand A, captured when `start` is accepted.
- `b`  in  16  operand B, captured when `start` is accepted.
- `c_in`  in  1  carry-in for add; ignored when `sub`=1.
- `busy`  out  1  high while nibbles are being processed.
- `done`  out  1  one-cycle pulse; result outputs valid from this cycle.
- `sum`  out  16  result; holds until next completion.
- `c_out`  out  1  carry out of bit 15 (for subtract, 1 = no borrow).
- `ovf`  out  1  signed overflow: carry into bit 15 XOR carry out of bit 15.

## Operation
- Internal: `a_r`, `b_r` (16-bit, `b_r` = ~b when `sub`), carry register `cy`, nibble index `idx` (2-bit), accumulator `acc` (16-bit), state.
- States: IDLE, ADD, DONE.
  - IDLE: `start`=1 → capture operands; `cy` ← (`sub` ? 1 : `c_in`); `idx` ← 0; go to ADD. Otherwise stay.
  - ADD: adder inputs `a_r[4·idx+3:4·idx]`, `b_r[...]`, `cy`; register adder sum into `acc[4·idx+3:4·idx]`, adder c_out into `cy`; `idx` ← idx+1. When `idx`=3 at the edge: copy final `acc` (with nibble 3 included) to `sum`, `cy` result to `c_out`, compute `ovf`, go to DONE.
  - DONE: `done`=1 for exactly this cycle. `start`=1 → accepted exactly as in IDLE (back-to-back op, goes to ADD); else go to IDLE.
- `start` in ADD is ignored (not queued).
- Operand inputs may change freely after the accepting edge; only captured copies are used.
- `ovf` needs the carry into bit 15: derive as `a_r[15]` ^ `b_r[15]` ^ adder sum bit 3 during nibble 3.
- Arithmetic modulo 2^16; `sub` uses two's complement (invert B, carry-in 1). `c_in` has no effect when `sub`=1.
- `sum`, `c_out`, `ovf` are updated only on transition ADD→DONE; never show partial results.

## Timing
- Reset (`clr`=1, any time including mid-ADD): state IDLE, `busy`=0, `done`=0, `sum`=0, `c_out`=0, `ovf`=0, `idx`=0, `cy`=0, `acc`=0; an in-flight operation is discarded and no `done` is produced.
- Start accepted at edge E0 → `busy`=1 for cycles after E0, E1, E2, E3 (4 cycles, nibbles 0..3 registered at E1..E4).
- Results and `done`=1 in the cycle after E4; `busy`=0 in that cycle.
- Latency: start edge to `done` = 5 cycles. Back-to-back throughput: one result per 5 cycles (start held high continuously).
- `busy` and `done` are never high simultaneously; both are registered outputs (decoded from state register).

## Test plan
- Reset mid-op: start a=0xFFFF,b=0x0001, assert `clr` after 2 ADD cycles → outputs all 0, IDLE, no `done` pulse afterwards.
- Basic add: a=0x1234, b=0x4321, c_in=0, sub=0 → `done` 5 cycles after start, sum=0x5555, c_out=0, ovf=0; `busy` high exactly 4 cycles.
- Full carry ripple: a=0xFFFF, b=0x0000, c_in=1 → sum=0x0000, c_out=1, ovf=0; a=0x7FFF, b=0x0001 → sum=0x8000, c_out=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, c_out=0; a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, c_out=1, ovf=1; c_in=1 must not change either.
- Handshake: `start` pulsed during ADD with new operands → ignored, first result unchanged; `start` held high continuously with changing operands → `done` every 5 cycles, each result matches operands present at its accepting edge.
- Hold: after `done`, change a/b without start → `sum`, `c_out`, `ovf` remain stable for 20 cycles.
